// File: rtl/johnson_phase_monitor.sv
// Monitors a 4-bit Johnson code stream: decodes phase, checks successor order,
// tracks lock and counts completed laps and sequence errors.
//
//   state  | meaning
//   UNLOCK | no legal reference code yet, or last code was illegal
//   ACQ    | counting consecutive legal successor transitions toward lock
//   LOCKED | sequence verified; deviations raise err, 1000->0000 raises lap_pulse
module johnson_phase_monitor #(
  parameter int LOCK_N = 4,
  parameter int LAP_W  = 8,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             smp,
  input  logic [3:0]       count,
  input  logic             clr,
  output logic [2:0]       phase,
  output logic             phase_vld,
  output logic [7:0]       phase_oh,
  output logic             locked,
  output logic             lap_pulse,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_C  = LOCK_N[3:0];
  localparam logic [LAP_W-1:0] LAP_ONE = {{(LAP_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t     state, state_nxt;
  logic [3:0] acq_cnt, acq_nxt;
  logic [3:0] prev;
  logic       legal;
  logic [2:0] dec_phase;
  logic       is_succ;
  logic       lap_evt;
  logic       err_evt;

  always_comb begin
    legal     = 1'b1;
    dec_phase = 3'd0;
    case (count)
      4'b0000: dec_phase = 3'd0;
      4'b0001: dec_phase = 3'd1;
      4'b0011: dec_phase = 3'd2;
      4'b0111: dec_phase = 3'd3;
      4'b1111: dec_phase = 3'd4;
      4'b1110: dec_phase = 3'd5;
      4'b1100: dec_phase = 3'd6;
      4'b1000: dec_phase = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  assign is_succ = (count == {prev[2:0], ~prev[3]});

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= UNLOCK;
      acq_cnt <= 4'd0;
      prev    <= 4'b0000;
    end else begin
      state   <= state_nxt;
      acq_cnt <= acq_nxt;
      if (smp) prev <= count;
    end
  end

  always_comb begin
    state_nxt = state;
    acq_nxt   = acq_cnt;
    lap_evt   = 1'b0;
    err_evt   = 1'b0;
    if (smp) begin
      case (state)
        UNLOCK: begin
          if (legal) begin
            state_nxt = ACQ;
            acq_nxt   = 4'd0;
          end
        end
        ACQ: begin
          if (!legal) begin
            state_nxt = UNLOCK;
            acq_nxt   = 4'd0;
          end else if (is_succ) begin
            if (acq_cnt + 4'd1 == LOCK_C) begin
              state_nxt = LOCKED;
              acq_nxt   = 4'd0;
            end else begin
              acq_nxt = acq_cnt + 4'd1;
            end
          end else begin
            acq_nxt = 4'd0;
          end
        end
        LOCKED: begin
          // prev is always legal here, so a successor match implies a legal code
          if (is_succ) begin
            lap_evt = (prev == 4'b1000);
          end else begin
            err_evt   = 1'b1;
            state_nxt = legal ? ACQ : UNLOCK;
            acq_nxt   = 4'd0;
          end
        end
        default: begin
          state_nxt = UNLOCK;
          acq_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase     <= 3'd0;
      phase_vld <= 1'b0;
      phase_oh  <= 8'h00;
      lap_pulse <= 1'b0;
      err       <= 1'b0;
      lap_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      lap_pulse <= lap_evt;
      err       <= err_evt;
      if (smp) begin
        phase_vld <= legal;
        if (legal) begin
          phase    <= dec_phase;
          phase_oh <= 8'd1 << dec_phase;
        end else begin
          phase_oh <= 8'h00;
        end
      end
      if (clr) begin
        lap_cnt <= '0;
        err_cnt <= '0;
      end else begin
        if (lap_evt) lap_cnt <= lap_cnt + LAP_ONE;
        if (err_evt && err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor: vector table for lock/error/clear
// sequences, plus hand sequences for lap wrap, LOCK_N=1 and async reset.
module tb_johnson_phase_monitor;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       smp;
  logic [3:0] count;
  logic       clr;

  logic [2:0] phase;
  logic       phase_vld;
  logic [7:0] phase_oh;
  logic       locked;
  logic       lap_pulse;
  logic [1:0] lap_cnt;
  logic       err;
  logic [1:0] err_cnt;

  logic [2:0] d2_phase;
  logic       d2_phase_vld;
  logic [7:0] d2_phase_oh;
  logic       d2_locked;
  logic       d2_lap_pulse;
  logic [7:0] d2_lap_cnt;
  logic       d2_err;
  logic [7:0] d2_err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  johnson_phase_monitor #(.LOCK_N(4), .LAP_W(2), .ERR_W(2)) dut (
    .clk(clk), .n_rst(n_rst), .smp(smp), .count(count), .clr(clr),
    .phase(phase), .phase_vld(phase_vld), .phase_oh(phase_oh), .locked(locked),
    .lap_pulse(lap_pulse), .lap_cnt(lap_cnt), .err(err), .err_cnt(err_cnt)
  );

  johnson_phase_monitor #(.LOCK_N(1), .LAP_W(8), .ERR_W(8)) dut_l1 (
    .clk(clk), .n_rst(n_rst), .smp(smp), .count(count), .clr(clr),
    .phase(d2_phase), .phase_vld(d2_phase_vld), .phase_oh(d2_phase_oh), .locked(d2_locked),
    .lap_pulse(d2_lap_pulse), .lap_cnt(d2_lap_cnt), .err(d2_err), .err_cnt(d2_err_cnt)
  );

  typedef struct {
    logic        smp;
    logic [3:0]  cnt;
    logic        clr;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] ex(int ph, bit vld, int oh, bit lk, bit lap, int lc, bit e, int ec);
    return {3'(ph), vld, 8'(oh), lk, lap, 2'(lc), e, 2'(ec)};
  endfunction

  task automatic add(input logic s, input logic [3:0] c, input logic cl, input logic [18:0] e);
    vec_t v;
    v.smp = s; v.cnt = c; v.clr = cl; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [18:0] outs();
    return {phase, phase_vld, phase_oh, locked, lap_pulse, lap_cnt, err, err_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic step(input logic s, input logic [3:0] c, input logic cl);
    @(negedge clk);
    smp = s; count = c; clr = cl;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] jc [8];
  int         pulses;

  initial begin
    jc[0] = 4'b0000; jc[1] = 4'b0001; jc[2] = 4'b0011; jc[3] = 4'b0111;
    jc[4] = 4'b1111; jc[5] = 4'b1110; jc[6] = 4'b1100; jc[7] = 4'b1000;

    // lock and first lap
    add(1, 4'b0000, 0, ex(0, 1, 8'h01, 0, 0, 0, 0, 0));
    add(1, 4'b0001, 0, ex(1, 1, 8'h02, 0, 0, 0, 0, 0));
    add(1, 4'b0011, 0, ex(2, 1, 8'h04, 0, 0, 0, 0, 0));
    add(1, 4'b0111, 0, ex(3, 1, 8'h08, 0, 0, 0, 0, 0));
    add(1, 4'b1111, 0, ex(4, 1, 8'h10, 1, 0, 0, 0, 0));
    add(1, 4'b1110, 0, ex(5, 1, 8'h20, 1, 0, 0, 0, 0));
    add(1, 4'b1100, 0, ex(6, 1, 8'h40, 1, 0, 0, 0, 0));
    add(1, 4'b1000, 0, ex(7, 1, 8'h80, 1, 0, 0, 0, 0));
    add(1, 4'b0000, 0, ex(0, 1, 8'h01, 1, 1, 1, 0, 0));
    add(1, 4'b0001, 0, ex(1, 1, 8'h02, 1, 0, 1, 0, 0));
    // illegal while locked, then reacquire
    add(1, 4'b0101, 0, ex(1, 0, 8'h00, 0, 0, 1, 1, 1));
    add(1, 4'b0000, 0, ex(0, 1, 8'h01, 0, 0, 1, 0, 1));
    add(1, 4'b0001, 0, ex(1, 1, 8'h02, 0, 0, 1, 0, 1));
    add(1, 4'b0011, 0, ex(2, 1, 8'h04, 0, 0, 1, 0, 1));
    add(1, 4'b0111, 0, ex(3, 1, 8'h08, 0, 0, 1, 0, 1));
    add(1, 4'b1111, 0, ex(4, 1, 8'h10, 1, 0, 1, 0, 1));
    // smp=0 freezes, then a repeated sample is an error
    add(0, 4'b1010, 0, ex(4, 1, 8'h10, 1, 0, 1, 0, 1));
    add(0, 4'b1010, 0, ex(4, 1, 8'h10, 1, 0, 1, 0, 1));
    add(0, 4'b1010, 0, ex(4, 1, 8'h10, 1, 0, 1, 0, 1));
    add(1, 4'b1111, 0, ex(4, 1, 8'h10, 0, 0, 1, 1, 2));
    // relock from ACQ; 1000->0000 while acquiring is not a lap
    add(1, 4'b1110, 0, ex(5, 1, 8'h20, 0, 0, 1, 0, 2));
    add(1, 4'b1100, 0, ex(6, 1, 8'h40, 0, 0, 1, 0, 2));
    add(1, 4'b1000, 0, ex(7, 1, 8'h80, 0, 0, 1, 0, 2));
    add(1, 4'b0000, 0, ex(0, 1, 8'h01, 1, 0, 1, 0, 2));
    add(1, 4'b0011, 0, ex(2, 1, 8'h04, 0, 0, 1, 1, 3));
    add(1, 4'b0111, 0, ex(3, 1, 8'h08, 0, 0, 1, 0, 3));
    add(1, 4'b1111, 0, ex(4, 1, 8'h10, 0, 0, 1, 0, 3));
    add(1, 4'b1110, 0, ex(5, 1, 8'h20, 0, 0, 1, 0, 3));
    add(1, 4'b1100, 0, ex(6, 1, 8'h40, 1, 0, 1, 0, 3));
    add(1, 4'b1100, 0, ex(6, 1, 8'h40, 0, 0, 1, 1, 3));
    // repeat while acquiring: no error, acquisition restarts
    add(1, 4'b1100, 0, ex(6, 1, 8'h40, 0, 0, 1, 0, 3));
    add(1, 4'b1000, 0, ex(7, 1, 8'h80, 0, 0, 1, 0, 3));
    add(1, 4'b0000, 0, ex(0, 1, 8'h01, 0, 0, 1, 0, 3));
    add(1, 4'b0001, 0, ex(1, 1, 8'h02, 0, 0, 1, 0, 3));
    add(1, 4'b0011, 0, ex(2, 1, 8'h04, 1, 0, 1, 0, 3));
    add(1, 4'b1001, 0, ex(2, 0, 8'h00, 0, 0, 1, 1, 3));
    add(1, 4'b0011, 0, ex(2, 1, 8'h04, 0, 0, 1, 0, 3));
    add(1, 4'b0111, 0, ex(3, 1, 8'h08, 0, 0, 1, 0, 3));
    add(1, 4'b1111, 0, ex(4, 1, 8'h10, 0, 0, 1, 0, 3));
    add(1, 4'b1110, 0, ex(5, 1, 8'h20, 0, 0, 1, 0, 3));
    add(1, 4'b1100, 0, ex(6, 1, 8'h40, 1, 0, 1, 0, 3));
    // clr in the same cycle as a violation, then clr with smp=0
    add(1, 4'b0110, 1, ex(6, 0, 8'h00, 0, 0, 0, 1, 0));
    add(0, 4'b0110, 1, ex(6, 0, 8'h00, 0, 0, 0, 0, 0));

    n_rst = 1'b0; smp = 1'b0; count = 4'b0000; clr = 1'b0;
    #12;
    chk("reset_outs", 32'(outs()), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].smp, vecs[i].cnt, vecs[i].clr);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // LOCK_N=1 instance locks on the first successor; then 5 laps wrap lap_cnt
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, jc[k], 0);
      if (lap_pulse) pulses++;
      if (k == 0) chk("l1_not_locked", 32'(d2_locked), 32'd0);
      if (k == 1) chk("l1_locked", 32'(d2_locked), 32'd1);
      if (k == 4) chk("relock", 32'(locked), 32'd1);
    end
    for (int lap = 0; lap < 5; lap++) begin
      for (int k = 0; k < 8; k++) begin
        step(1, jc[k], 0);
        if (lap_pulse) pulses++;
        chk($sformatf("lap%0d_pulse%0d", lap, k), 32'(lap_pulse), (k == 0) ? 32'd1 : 32'd0);
      end
    end
    chk("lap_pulses", 32'(pulses), 32'd5);
    chk("lap_wrap", 32'(lap_cnt), 32'd1);
    chk("still_locked", 32'(locked), 32'd1);

    // async reset mid-operation, away from any clock edge
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs()), 32'd0);
    chk("async_reset_l1", 32'(d2_locked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
